// File: rtl/nibble_demux_assembler_if.sv
// Handshake bundle between a 4-bit nibble producer, the nibble demux assembler
// and an 8-bit byte consumer.
interface nibble_demux_assembler_if;
  logic [3:0] in_nib;
  logic       in_valid;
  logic       in_ready;
  logic       sel;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;
  logic       timeout_err;

  modport master (
    output in_nib,
    output in_valid,
    input  in_ready,
    input  sel,
    input  out_byte,
    input  out_valid,
    output out_ready,
    input  timeout_err
  );

  modport slave (
    input  in_nib,
    input  in_valid,
    output in_ready,
    output sel,
    output out_byte,
    output out_valid,
    input  out_ready,
    output timeout_err
  );
endinterface

// File: rtl/nibble_demux_assembler.sv
// Assembles pairs of 4-bit nibbles into bytes (inverse of the 2:1 nibble mux).
// Optional half-byte timeout is enabled by defining NIBBLE_DEMUX_TIMEOUT_EN.
module nibble_demux_assembler #(
  parameter int LOW_FIRST = 1,
  parameter int TIMEOUT   = 15
) (
  input logic                          clk,
  input logic                          rst,
  nibble_demux_assembler_if.slave      bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_e;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : gBadTimeout
    $error("nibble_demux_assembler: TIMEOUT must be in 1..255");
  end

  state_e     state_q;
  state_e     state_d;
  logic [7:0] outByte_q;
  logic [7:0] outByte_d;
  logic       inXfer;
  logic       outXfer;
  logic       writeFirst;
  logic       writeSecond;

  assign bus.in_ready  = (state_q != FULL) | bus.out_ready;
  assign bus.sel       = (state_q == HALF);
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_byte  = outByte_q;

  assign inXfer  = bus.in_valid & bus.in_ready;
  assign outXfer = bus.out_valid & bus.out_ready;

`ifdef NIBBLE_DEMUX_TIMEOUT_EN
  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  logic [7:0] tmoCount_q;
  logic [7:0] tmoCount_d;
  logic       tmoErr_q;
  logic       tmoErr_d;

  assign bus.timeout_err = tmoErr_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  // Next-state logic; FULL with a simultaneous output and input transfer
  // restarts the next byte immediately so streaming has no bubble.
  always_comb begin
    state_d     = state_q;
    writeFirst  = 1'b0;
    writeSecond = 1'b0;
`ifdef NIBBLE_DEMUX_TIMEOUT_EN
    tmoCount_d  = 8'd0;
    tmoErr_d    = 1'b0;
`endif
    case (state_q)
      EMPTY: begin
        if (inXfer) begin
          writeFirst = 1'b1;
          state_d    = HALF;
        end
      end
      HALF: begin
        if (inXfer) begin
          writeSecond = 1'b1;
          state_d     = FULL;
        end
`ifdef NIBBLE_DEMUX_TIMEOUT_EN
        else if (tmoCount_q == TmoLast) begin
          state_d  = EMPTY;
          tmoErr_d = 1'b1;
        end else begin
          tmoCount_d = tmoCount_q + 8'd1;
        end
`endif
      end
      FULL: begin
        if (outXfer) begin
          if (inXfer) begin
            writeFirst = 1'b1;
            state_d    = HALF;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Steer the accepted nibble into its half; the other half is left untouched.
  always_comb begin
    outByte_d = outByte_q;
    if (writeFirst) begin
      if (LOW_FIRST != 0) outByte_d[3:0] = bus.in_nib;
      else                outByte_d[7:4] = bus.in_nib;
    end else if (writeSecond) begin
      if (LOW_FIRST != 0) outByte_d[7:4] = bus.in_nib;
      else                outByte_d[3:0] = bus.in_nib;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      outByte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      outByte_q <= outByte_d;
    end
  end

`ifdef NIBBLE_DEMUX_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmoCount_q <= 8'd0;
      tmoErr_q   <= 1'b0;
    end else begin
      tmoCount_q <= tmoCount_d;
      tmoErr_q   <= tmoErr_d;
    end
  end
`endif

  // A presented byte must not change until the consumer takes it.
  assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready) |=> $stable(bus.out_byte));

endmodule

// File: tb/tb_nibble_demux_assembler.sv
// Directed self-checking bench for nibble_demux_assembler: one instance with
// LOW_FIRST=1/TIMEOUT=4 and one with LOW_FIRST=0.
module tb_nibble_demux_assembler;

  logic clk = 1'b0;
  logic rst;
  int   errorCount = 0;
  int   checkCount = 0;

  always #5 clk = ~clk;

  nibble_demux_assembler_if busA ();
  nibble_demux_assembler_if busB ();

  nibble_demux_assembler #(.LOW_FIRST(1), .TIMEOUT(4)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA.slave)
  );

  nibble_demux_assembler #(.LOW_FIRST(0), .TIMEOUT(15)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] nib,
                               input logic outReady);
    busA.in_valid  = valid;
    busA.in_nib    = nib;
    busA.out_ready = outReady;
  endtask

  // Advance one clock; outputs are then observed 1 time unit after the edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 4'h0, 1'b1);
    busB.in_valid  = 1'b0;
    busB.in_nib    = 4'h0;
    busB.out_ready = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("reset out_valid", 32'(busA.out_valid), 32'd0);
    checkOutput("reset sel", 32'(busA.sel), 32'd0);
    checkOutput("reset out_byte", 32'(busA.out_byte), 32'h00);
    checkOutput("reset timeout_err", 32'(busA.timeout_err), 32'd0);
    checkOutput("reset in_ready", 32'(busA.in_ready), 32'd1);
    rst = 1'b0;

    // Basic assembly, low nibble first.
    applyStimulus(1'b1, 4'hA, 1'b1);
    #1 checkOutput("basic sel0", 32'(busA.sel), 32'd0);
    stepCycle();
    checkOutput("basic sel1", 32'(busA.sel), 32'd1);
    checkOutput("basic half no valid", 32'(busA.out_valid), 32'd0);
    applyStimulus(1'b1, 4'h5, 1'b1);
    stepCycle();
    checkOutput("basic out_valid", 32'(busA.out_valid), 32'd1);
    checkOutput("basic out_byte", 32'(busA.out_byte), 32'h5A);
    checkOutput("basic sel2", 32'(busA.sel), 32'd0);
    applyStimulus(1'b0, 4'h0, 1'b1);
    stepCycle();
    checkOutput("basic valid drops", 32'(busA.out_valid), 32'd0);

    // High nibble first on the second instance.
    busB.in_valid = 1'b1;
    busB.in_nib   = 4'h3;
    stepCycle();
    busB.in_nib   = 4'hC;
    stepCycle();
    busB.in_valid = 1'b0;
    checkOutput("hifirst out_valid", 32'(busB.out_valid), 32'd1);
    checkOutput("hifirst out_byte", 32'(busB.out_byte), 32'h3C);
    stepCycle();

    // Backpressure holds the byte and blocks the input.
    applyStimulus(1'b1, 4'h1, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 4'h2, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 4'hF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("bp in_ready %0d", i), 32'(busA.in_ready), 32'd0);
      checkOutput($sformatf("bp out_valid %0d", i), 32'(busA.out_valid), 32'd1);
      checkOutput($sformatf("bp out_byte %0d", i), 32'(busA.out_byte), 32'h21);
      stepCycle();
    end
    applyStimulus(1'b1, 4'hF, 1'b1);
    #1 checkOutput("bp release in_ready", 32'(busA.in_ready), 32'd1);
    stepCycle();
    checkOutput("bp zero-bubble sel", 32'(busA.sel), 32'd1);
    checkOutput("bp zero-bubble valid", 32'(busA.out_valid), 32'd0);
    applyStimulus(1'b1, 4'h3, 1'b1);
    stepCycle();
    checkOutput("bp next byte", 32'(busA.out_byte), 32'h3F);
    checkOutput("bp next valid", 32'(busA.out_valid), 32'd1);
    applyStimulus(1'b0, 4'h0, 1'b1);
    stepCycle();

    // Streaming 1..6 with both handshakes held high.
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b1);
      stepCycle();
      if (i % 2 == 0) begin
        checkOutput($sformatf("stream valid %0d", i), 32'(busA.out_valid), 32'd1);
        checkOutput($sformatf("stream byte %0d", i), 32'(busA.out_byte),
                    32'({4'(i), 4'(i - 1)}));
      end else begin
        checkOutput($sformatf("stream valid %0d", i), 32'(busA.out_valid), 32'd0);
        checkOutput($sformatf("stream sel %0d", i), 32'(busA.sel), 32'd1);
      end
    end
    applyStimulus(1'b0, 4'h0, 1'b1);
    stepCycle();

    // Reset in the middle of a byte throws away the held nibble.
    applyStimulus(1'b1, 4'h7, 1'b1);
    stepCycle();
    checkOutput("midrst half", 32'(busA.sel), 32'd1);
    applyStimulus(1'b0, 4'h0, 1'b1);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("midrst sel", 32'(busA.sel), 32'd0);
    checkOutput("midrst out_byte", 32'(busA.out_byte), 32'h00);
    applyStimulus(1'b1, 4'h1, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 4'h2, 1'b1);
    stepCycle();
    checkOutput("midrst valid", 32'(busA.out_valid), 32'd1);
    checkOutput("midrst byte", 32'(busA.out_byte), 32'h21);
    applyStimulus(1'b0, 4'h0, 1'b1);
    stepCycle();

`ifdef NIBBLE_DEMUX_TIMEOUT_EN
    // Idle in HALF for TIMEOUT cycles discards the nibble and flags an error.
    applyStimulus(1'b1, 4'h9, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 4'h0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      stepCycle();
      checkOutput($sformatf("tmo wait sel %0d", i), 32'(busA.sel), 32'd1);
      checkOutput($sformatf("tmo wait err %0d", i), 32'(busA.timeout_err), 32'd0);
    end
    stepCycle();
    checkOutput("tmo sel empty", 32'(busA.sel), 32'd0);
    checkOutput("tmo err pulse", 32'(busA.timeout_err), 32'd1);
    applyStimulus(1'b1, 4'h1, 1'b1);
    stepCycle();
    checkOutput("tmo err clears", 32'(busA.timeout_err), 32'd0);
    applyStimulus(1'b1, 4'h8, 1'b1);
    stepCycle();
    checkOutput("tmo after valid", 32'(busA.out_valid), 32'd1);
    checkOutput("tmo after byte", 32'(busA.out_byte), 32'h81);
    applyStimulus(1'b0, 4'h0, 1'b1);
    stepCycle();

    // Second nibble exactly at the limit is accepted without error.
    applyStimulus(1'b1, 4'h9, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 4'h0, 1'b1);
    for (int i = 1; i <= 3; i++) stepCycle();
    applyStimulus(1'b1, 4'h4, 1'b1);
    stepCycle();
    checkOutput("tmo edge valid", 32'(busA.out_valid), 32'd1);
    checkOutput("tmo edge byte", 32'(busA.out_byte), 32'h49);
    checkOutput("tmo edge err", 32'(busA.timeout_err), 32'd0);
    applyStimulus(1'b0, 4'h0, 1'b1);
    stepCycle();
    checkOutput("tmo edge err later", 32'(busA.timeout_err), 32'd0);
`else
    // Without the timeout the block waits in HALF indefinitely.
    applyStimulus(1'b1, 4'h9, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 4'h0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      stepCycle();
      checkOutput($sformatf("wait sel %0d", i), 32'(busA.sel), 32'd1);
      checkOutput($sformatf("wait err %0d", i), 32'(busA.timeout_err), 32'd0);
    end
    applyStimulus(1'b1, 4'h8, 1'b1);
    stepCycle();
    checkOutput("wait byte", 32'(busA.out_byte), 32'h89);
    checkOutput("wait valid", 32'(busA.out_valid), 32'd1);
    applyStimulus(1'b0, 4'h0, 1'b1);
    stepCycle();
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/nibble_demux_assembler.md
Name: nibble_demux_assembler

Overview:
- Receives a stream of 4-bit nibbles and steers alternate nibbles into the low and high halves of an 8-bit byte register, then presents the assembled byte downstream.
- It is the inverse of the 2:1 nibble mux that serializes a byte onto a 4-bit path via `sel`.
- It sits between a 4-bit producer (display/debug nibble bus, serial nibble link) and 8-bit consumers on the simplex8 datapath.

Parameters:
- LOW_FIRST, 1: 1 = first nibble of each byte goes to bits [3:0]; 0 = first nibble goes to bits [7:4].
- TIMEOUT, 15: cycles allowed between first and second nibble (used only with the optional feature); legal range 1..255.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_nib  input  4  incoming nibble.
- in_valid  input  1  in_nib is valid this cycle.
- in_ready  output  1  block can accept a nibble this cycle.
- sel  output  1  half the next accepted nibble fills: 0 = first half, 1 = second half. Mirrors the mux select.
- out_byte  output  8  assembled byte, stable while out_valid=1.
- out_valid  output  1  out_byte holds a complete byte.
- out_ready  input  1  consumer accepts out_byte this cycle.
- timeout_err  output  1  one-cycle pulse when a half byte is discarded; only present with the optional feature, otherwise tied 0.

Behaviour:
- Handshakes:
  - An input transfer occurs on a cycle with in_valid & in_ready.
  - An output transfer occurs on a cycle with out_valid & out_ready.
- States:
  - EMPTY: no nibble held.
  - HALF: first nibble held.
  - FULL: byte complete.
- Reset (rst=1 at a clock edge), regardless of state or in-flight transfer:
  - State → EMPTY.
  - out_byte = 8'h00, out_valid = 0, sel = 0, timeout_err = 0.
  - Any partial byte is lost.
- Combinational outputs:
  - in_ready = (state != FULL) | out_ready.
  - sel = (state == HALF).
  - out_valid = (state == FULL).
- Placement of nibbles:
  - First nibble goes to half H1 = LOW_FIRST ? [3:0] : [7:4].
  - Second nibble goes to the other half, H2.
- EMPTY:
  - Input transfer → write H1, go to HALF.
  - Otherwise stay in EMPTY.
- HALF:
  - Input transfer → write H2, go to FULL.
  - out_byte is updated only in its written half; the other half keeps its value.
- FULL:
  - Output transfer with no input transfer → EMPTY.
  - Output transfer and input transfer in the same cycle → write H1, go to HALF (zero-bubble).
  - No output transfer → hold; in_ready = 0, so in_nib is ignored.
- Latency:
  - out_valid rises on the cycle after the second nibble is accepted.
  - Sustained throughput is 1 byte per 2 cycles when in_valid and out_ready are held high.
- out_byte keeps its last value after an output transfer (not cleared). Benches check out_byte only while out_valid = 1.
- in_valid low while in HALF: the block waits indefinitely unless the optional feature is enabled.

Optional Feature:
- Macro: NIBBLE_DEMUX_TIMEOUT_EN.
- Enabled:
  - An 8-bit counter clears on entry to HALF and increments each cycle spent in HALF with no input transfer.
  - When the counter reaches TIMEOUT with no input transfer that cycle, the block returns to EMPTY and discards the held half.
  - timeout_err pulses high for exactly one cycle, the cycle after the discard.
  - A nibble arriving on the same cycle the counter hits TIMEOUT is accepted as the second nibble; no error is raised.
  - Counter and timeout_err are cleared by rst.
- Disabled:
  - No counter logic.
  - timeout_err is driven constant 0.
  - HALF waits forever.

Test Plan:
- Reset then basic assembly, LOW_FIRST=1, out_ready=1: nibbles 4'hA then 4'h5 on consecutive cycles → out_valid=1 for one cycle with out_byte=8'h5A; sel sequence is 0,1,0.
- LOW_FIRST=0: nibbles 4'h3 then 4'hC → out_byte=8'h3C.
- Backpressure: out_ready=0 after assembling 8'h21, in_valid held with 4'hF → in_ready=0, out_byte stays 8'h21 for 5 cycles. Then raise out_ready → the byte transfers and 4'hF is accepted the same cycle (state HALF).
- Streaming: in_valid=1 and out_ready=1 continuously with nibbles 1,2,3,4,5,6 → bytes 8'h21, 8'h43, 8'h65 on every other cycle, no dropped nibble.
- Reset mid-byte: accept 4'h7, assert rst for one cycle, then send 4'h1, 4'h2 → out_byte=8'h21 (the 7 is discarded); sel=0 after reset.
- With NIBBLE_DEMUX_TIMEOUT_EN, TIMEOUT=4: accept 4'h9, idle 4 cycles → timeout_err pulses once and the block is back in EMPTY. Next pair 4'h1, 4'h8 → 8'h81. Repeat with the second nibble arriving exactly at the count → no error, and the byte assembles.
